// File: rtl/kbdmus_loader.sv
// Framed packet loader between the AVR SPI byte stream and the keyboard/mouse/Kempston
// holding registers. Payloads are collected in a shadow register; strobes fire only after a full packet.
module kbdmus_loader #(
   parameter int TIMEOUT = 4095
) (
   input  logic        fclk,
   input  logic        rst,
   input  logic        frame,
   input  logic [7:0]  in_data,
   input  logic        in_stb,
   output logic [39:0] kbd_out,
   output logic        kbd_stb,
   output logic [7:0]  mus_out,
   output logic        mus_xstb,
   output logic        mus_ystb,
   output logic        mus_btnstb,
   output logic        kj_stb,
   output logic        err
);

   // state    | meaning
   // IDLE     | waiting for a fresh frame rising edge
   // HDR_WAIT | frame open, expecting the header byte
   // KBD      | collecting 5 keyboard bytes
   // MUS      | collecting X, Y, buttons
   // KJ       | collecting the Kempston byte
   // EMIT_K   | loading kbd_out
   // EMIT_X   | presenting mouse X
   // EMIT_Y   | presenting mouse Y
   // EMIT_B   | presenting mouse buttons
   // EMIT_J   | presenting Kempston data
   typedef enum logic [3:0] {
      IDLE, HDR_WAIT, KBD, MUS, KJ, EMIT_K, EMIT_X, EMIT_Y, EMIT_B, EMIT_J
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [2:0]    cnt, cnt_nxt;
   logic [TW-1:0] tmo, tmo_nxt;
   logic [39:0]   shadow, shadow_nxt;
   logic          armed, armed_nxt;
   logic [39:0]   kbd_out_nxt;
   logic [7:0]    mus_out_nxt;
   logic          kbd_stb_nxt, mus_xstb_nxt, mus_ystb_nxt, mus_btnstb_nxt, kj_stb_nxt, err_nxt;
   logic          last_byte, tmo_hit;

   // abort lands on the edge where the idle count would reach TIMEOUT
   assign tmo_hit   = (tmo == TW'(TIMEOUT - 1));
   assign last_byte = (state == KBD && cnt == 3'd4) || (state == MUS && cnt == 3'd2) || (state == KJ);

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      tmo_nxt        = tmo;
      shadow_nxt     = shadow;
      armed_nxt      = armed | ~frame;
      kbd_out_nxt    = kbd_out;
      mus_out_nxt    = mus_out;
      kbd_stb_nxt    = 1'b0;
      mus_xstb_nxt   = 1'b0;
      mus_ystb_nxt   = 1'b0;
      mus_btnstb_nxt = 1'b0;
      kj_stb_nxt     = 1'b0;
      err_nxt        = 1'b0;
      case (state)
         IDLE: begin
            if (frame && armed) begin
               state_nxt = HDR_WAIT;
               armed_nxt = 1'b0;
            end
         end
         HDR_WAIT: begin
            if (!frame) begin
               state_nxt = IDLE;
            end else if (in_stb) begin
               cnt_nxt    = 3'd0;
               tmo_nxt    = '0;
               shadow_nxt = '0;
               case (in_data)
                  8'h01:   state_nxt = KBD;
                  8'h02:   state_nxt = MUS;
                  8'h03:   state_nxt = KJ;
                  default: begin
                     state_nxt = IDLE;
                     err_nxt   = 1'b1;
                  end
               endcase
            end
         end
         KBD, MUS, KJ: begin
            if (!frame || (!in_stb && tmo_hit)) begin
               state_nxt  = IDLE;
               shadow_nxt = '0;
               cnt_nxt    = 3'd0;
               err_nxt    = 1'b1;
            end else if (in_stb) begin
               shadow_nxt = {shadow[31:0], in_data};
               cnt_nxt    = cnt + 3'd1;
               tmo_nxt    = '0;
               if (last_byte) begin
                  case (state)
                     KBD:     state_nxt = EMIT_K;
                     MUS:     state_nxt = EMIT_X;
                     default: state_nxt = EMIT_J;
                  endcase
               end
            end else begin
               tmo_nxt = tmo + TW'(1);
            end
         end
         EMIT_K: begin
            kbd_out_nxt = shadow;
            kbd_stb_nxt = 1'b1;
            state_nxt   = IDLE;
         end
         EMIT_X: begin
            mus_out_nxt  = shadow[23:16];
            mus_xstb_nxt = 1'b1;
            state_nxt    = EMIT_Y;
         end
         EMIT_Y: begin
            mus_out_nxt  = shadow[15:8];
            mus_ystb_nxt = 1'b1;
            state_nxt    = EMIT_B;
         end
         EMIT_B: begin
            mus_out_nxt    = shadow[7:0];
            mus_btnstb_nxt = 1'b1;
            state_nxt      = IDLE;
         end
         EMIT_J: begin
            mus_out_nxt = shadow[7:0];
            kj_stb_nxt  = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // emission cannot take a byte; it is dropped and flagged
      if (state inside {EMIT_K, EMIT_X, EMIT_Y, EMIT_B, EMIT_J} && in_stb && frame)
         err_nxt = 1'b1;
   end

   always_ff @(posedge fclk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         tmo        <= '0;
         shadow     <= '0;
         armed      <= 1'b0;
         kbd_out    <= '0;
         mus_out    <= '0;
         kbd_stb    <= 1'b0;
         mus_xstb   <= 1'b0;
         mus_ystb   <= 1'b0;
         mus_btnstb <= 1'b0;
         kj_stb     <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         tmo        <= tmo_nxt;
         shadow     <= shadow_nxt;
         armed      <= armed_nxt;
         kbd_out    <= kbd_out_nxt;
         mus_out    <= mus_out_nxt;
         kbd_stb    <= kbd_stb_nxt;
         mus_xstb   <= mus_xstb_nxt;
         mus_ystb   <= mus_ystb_nxt;
         mus_btnstb <= mus_btnstb_nxt;
         kj_stb     <= kj_stb_nxt;
         err        <= err_nxt;
      end
   end

endmodule

// File: tb/tb_kbdmus_loader.sv
// Bench for kbdmus_loader: directed packets plus random packets, checked every cycle
// against a packet-level schedule of expected strobes, errors and held output values.
module tb_kbdmus_loader;

   localparam int TMO = 16;

   logic        fclk = 1'b0;
   logic        rst, frame, in_stb;
   logic [7:0]  in_data;
   logic [39:0] kbd_out;
   logic        kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb, err;
   logic [7:0]  mus_out;

   kbdmus_loader #(.TIMEOUT(TMO)) dut (
      .fclk(fclk), .rst(rst), .frame(frame), .in_data(in_data), .in_stb(in_stb),
      .kbd_out(kbd_out), .kbd_stb(kbd_stb), .mus_out(mus_out), .mus_xstb(mus_xstb),
      .mus_ystb(mus_ystb), .mus_btnstb(mus_btnstb), .kj_stb(kj_stb), .err(err)
   );

   always #5 fclk = ~fclk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // expected events keyed by cycle index; strobe bits are {k, x, y, b, j}
   logic [4:0]  ev_stb[int];
   logic        ev_err[int];
   logic [39:0] ev_kbd[int];
   logic [7:0]  ev_mus[int];
   logic [39:0] exp_kbd = '0;
   logic [7:0]  exp_mus = '0;
   logic [7:0]  pq[$];

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      logic [4:0] s;
      logic       e;
      @(posedge fclk);
      #1;
      cyc++;
      s = ev_stb.exists(cyc) ? ev_stb[cyc] : 5'b0;
      e = ev_err.exists(cyc) ? ev_err[cyc] : 1'b0;
      if (s[4]) exp_kbd = ev_kbd[cyc];
      if (|s[3:0]) exp_mus = ev_mus[cyc];
      chk("strobes", 40'({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb}), 40'(s));
      chk("err", 40'(err), 40'(e));
      chk("kbd_out", kbd_out, exp_kbd);
      chk("mus_out", 40'(mus_out), 40'(exp_mus));
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_data = b;
      in_stb  = 1'b1;
      tick();
      in_stb  = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic expect_stb(input int c, input logic [4:0] s, input logic [7:0] m, input logic [39:0] k);
      ev_stb[c] = s;
      ev_mus[c] = m;
      ev_kbd[c] = k;
   endtask

   task automatic expect_err(input int c);
      ev_err[c] = 1'b1;
   endtask

   // opens a frame, sends header + pq with legal spacing, schedules the expected emission
   task automatic send_packet(input logic [7:0] hdr);
      logic [39:0] k;
      int n;
      frame = 1'b1;
      idle(2);
      send_byte(hdr);
      idle(int'($urandom_range(3, 6)));
      foreach (pq[i]) begin
         send_byte(pq[i]);
         if (i < pq.size() - 1) idle(int'($urandom_range(3, 6)));
      end
      n = cyc;
      k = '0;
      case (hdr)
         8'h01: begin
            foreach (pq[i]) k = (k << 8) | 40'(pq[i]);
            expect_stb(n + 1, 5'b10000, 8'h00, k);
         end
         8'h02: begin
            expect_stb(n + 1, 5'b01000, pq[0], '0);
            expect_stb(n + 2, 5'b00100, pq[1], '0);
            expect_stb(n + 3, 5'b00010, pq[2], '0);
         end
         default: expect_stb(n + 1, 5'b00001, pq[0], '0);
      endcase
   endtask

   task automatic fill_pq(input int len);
      pq.delete();
      for (int i = 0; i < len; i++) pq.push_back(8'($urandom));
   endtask

   initial begin
      int kind;
      rst = 1'b1; frame = 1'b0; in_stb = 1'b0; in_data = 8'h00;
      idle(3);
      rst = 1'b0;
      idle(2);

      // keyboard
      pq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_packet(8'h01);
      frame = 1'b0;
      idle(5);
      chk("kbd_hold", kbd_out, 40'h11_2233_4455);

      // mouse, with a byte arriving during EMIT_X
      pq = '{8'h7F, 8'h80, 8'hFA};
      send_packet(8'h02);
      expect_err(cyc + 1);
      send_byte(8'h5A);
      frame = 1'b0;
      idle(5);

      // kempston, then a bad header whose frame carries more bytes
      pq = '{8'h1F};
      send_packet(8'h03);
      frame = 1'b0;
      idle(4);
      frame = 1'b1;
      idle(2);
      expect_err(cyc + 1);
      send_byte(8'h09);
      idle(4);
      send_byte(8'h01);
      idle(4);
      send_byte(8'h22);
      idle(4);
      frame = 1'b0;
      idle(3);

      // abort by frame drop mid-keyboard, then a normal keyboard packet
      frame = 1'b1;
      idle(2);
      send_byte(8'h01); idle(3);
      send_byte(8'hAA); idle(3);
      send_byte(8'hBB); idle(2);
      frame = 1'b0;
      expect_err(cyc + 1);
      idle(4);
      fill_pq(5);
      send_packet(8'h01);
      frame = 1'b0;
      idle(5);

      // inter-byte timeout in a mouse packet
      frame = 1'b1;
      idle(2);
      send_byte(8'h02); idle(3);
      send_byte(8'h05);
      expect_err(cyc + TMO);
      idle(TMO + 4);
      frame = 1'b0;
      idle(3);

      // frame drops on the same edge as the last payload byte
      frame = 1'b1;
      idle(2);
      send_byte(8'h03); idle(3);
      in_data = 8'h44; in_stb = 1'b1; frame = 1'b0;
      expect_err(cyc + 1);
      tick();
      in_stb = 1'b0;
      idle(4);

      // random packets, sometimes with trailing extra bytes in the same frame
      for (int p = 0; p < 24; p++) begin
         kind = int'($urandom_range(1, 3));
         fill_pq(kind == 1 ? 5 : (kind == 2 ? 3 : 1));
         send_packet(8'(kind));
         if ($urandom_range(0, 1) == 1) begin
            idle(4);
            send_byte(8'($urandom));
         end
         frame = 1'b0;
         idle(5);
      end

      // reset while mouse emission is under way: Y and buttons never appear
      fill_pq(3);
      send_packet(8'h02);
      idle(1);
      rst = 1'b1;
      frame = 1'b0;
      ev_stb.delete(); ev_err.delete(); ev_kbd.delete(); ev_mus.delete();
      exp_kbd = '0;
      exp_mus = '0;
      idle(3);
      rst = 1'b0;
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
